// File: rtl/ln_affine_stream.sv
// Streaming per-column affine stage: out = ((qin * gamma[col]) >>> SHIFT) + beta[col].
// Gamma/beta are reloaded over the parameter stream before every matrix.
module ln_affine_stream #(
  parameter int LANES        = 1,
  parameter int IN_W         = 22,
  parameter int G_W          = 16,
  parameter int B_W          = 32,
  parameter int OUT_W        = 32,
  parameter int MAX_N        = 768,
  parameter int SHIFT        = 8,
  parameter int MATRIXSIZE_W = 24
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [31:0]               p_tdata,
  input  logic                      p_tvalid,
  input  logic                      p_tlast,
  output logic                      p_tready,
  input  logic [LANES*IN_W-1:0]     qin_tdata,
  input  logic                      qin_tvalid,
  output logic                      qin_tready,
  output logic [LANES*OUT_W-1:0]    qout_tdata,
  output logic                      qout_tvalid,
  output logic                      qout_tlast,
  input  logic                      qout_tready,
  input  logic [MATRIXSIZE_W-1:0]   DIM1,
  input  logic [MATRIXSIZE_W-1:0]   DIM2,
  input  logic                      sat_en,
  output logic                      err_len,
  output logic                      loaded
);

  localparam int P_W   = IN_W + G_W;
  localparam int BIG_W = P_W + B_W + 1;
  localparam int ROWS  = MAX_N / LANES;
  localparam int RA_W  = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int LA_W  = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [MATRIXSIZE_W-1:0] ONE  = MATRIXSIZE_W'(1);
  localparam logic [MATRIXSIZE_W-1:0] STEP = MATRIXSIZE_W'(LANES);
  localparam logic [RA_W-1:0]         RA_ONE = RA_W'(1);
  localparam logic [LA_W-1:0]         LA_ONE = LA_W'(1);
  localparam logic signed [BIG_W-1:0] SAT_MAX = {{(BIG_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [BIG_W-1:0] SAT_MIN = {{(BIG_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  typedef enum logic [1:0] {LOAD_G, LOAD_B, RUN, DRAIN} state_t;
  state_t state, state_next;

  logic [MATRIXSIZE_W-1:0] dim1_r, dim2_r;
  logic                    sat_r;
  logic [MATRIXSIZE_W-1:0] ld_cnt;
  logic [RA_W-1:0]         ld_row;
  logic [LA_W-1:0]         ld_lane;
  logic [MATRIXSIZE_W-1:0] in_row;
  logic [RA_W-1:0]         in_idx, last_idx;
  logic [MATRIXSIZE_W-1:0] out_row, out_col;
  logic en, p_acc, q_acc, o_acc, ld_last, in_last, out_last, enter_load;

  assign en         = qout_tready | ~qout_tvalid;
  assign p_tready   = ~rst & ((state == LOAD_G) | (state == LOAD_B));
  assign qin_tready = ~rst & (state == RUN) & en;
  assign loaded     = ~rst & ((state == RUN) | (state == DRAIN));
  assign p_acc      = p_tvalid & p_tready;
  assign q_acc      = qin_tvalid & qin_tready;
  assign o_acc      = qout_tvalid & qout_tready;
  assign ld_last    = (ld_cnt == dim2_r - ONE);
  assign last_idx   = RA_W'((dim2_r / STEP) - ONE);
  assign in_last    = (in_row == dim1_r - ONE) && (in_idx == last_idx);
  assign out_last   = (out_row == dim1_r - ONE) && (out_col == dim2_r - STEP);
  assign qout_tlast = qout_tvalid & out_last;
  assign enter_load = (state != LOAD_G) && (state_next == LOAD_G);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state <= LOAD_G;
    else     state <= state_next;
  end

  // Word/beat counting alone drives the transitions; p_tlast only feeds err_len.
  always_comb begin
    // NOTE: default first so no path leaves state_next unassigned (which would infer a latch).
    state_next = state;
    case (state)
      LOAD_G:  if (p_acc && ld_last)        state_next = LOAD_B;
      LOAD_B:  if (p_acc && ld_last)        state_next = RUN;
      RUN:     if (q_acc && in_last)        state_next = DRAIN;
      DRAIN:   if (o_acc && qout_tlast)     state_next = LOAD_G;
      default:                              state_next = LOAD_G;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dim1_r  <= DIM1;
      dim2_r  <= DIM2;
      sat_r   <= sat_en;
      ld_cnt  <= '0;
      ld_row  <= '0;
      ld_lane <= '0;
      in_row  <= '0;
      in_idx  <= '0;
      out_row <= '0;
      out_col <= '0;
      err_len <= 1'b0;
    end else begin
      if (enter_load) begin
        dim1_r <= DIM1;
        dim2_r <= DIM2;
        sat_r  <= sat_en;
      end
      if (p_acc) begin
        if (p_tlast != ((state == LOAD_B) && ld_last)) err_len <= 1'b1;
        if (ld_last) begin
          ld_cnt  <= '0;
          ld_row  <= '0;
          ld_lane <= '0;
        end else begin
          ld_cnt <= ld_cnt + ONE;
          if (ld_lane == LA_W'(LANES - 1)) begin
            ld_lane <= '0;
            ld_row  <= ld_row + RA_ONE;
          end else begin
            ld_lane <= ld_lane + LA_ONE;
          end
        end
      end
      if (q_acc) begin
        if (in_idx == last_idx) begin
          in_idx <= '0;
          in_row <= in_last ? '0 : in_row + ONE;
        end else begin
          in_idx <= in_idx + RA_ONE;
        end
      end
      if (o_acc) begin
        if (out_col == dim2_r - STEP) begin
          out_col <= '0;
          out_row <= out_last ? '0 : out_row + ONE;
        end else begin
          out_col <= out_col + STEP;
        end
      end
    end
  end

  logic [LANES*G_W-1:0]  gmem [ROWS];
  logic [LANES*B_W-1:0]  bmem [ROWS];
  logic [LANES*G_W-1:0]  g_rd;
  logic [LANES*B_W-1:0]  b_rd, s2_beta;
  logic [LANES*IN_W-1:0] s1_q;
  logic signed [P_W-1:0] prod [LANES];
  logic s1_valid, s2_valid;

  // NOTE: memories and datapath registers carry no reset; only the valid chain needs a known state.
  always_ff @(posedge clk) begin
    if (p_acc && (state == LOAD_G)) gmem[ld_row][int'(ld_lane)*G_W +: G_W] <= p_tdata[G_W-1:0];
    if (p_acc && (state == LOAD_B)) bmem[ld_row][int'(ld_lane)*B_W +: B_W] <= p_tdata[B_W-1:0];
    if (en) begin
      s1_q    <= qin_tdata;
      g_rd    <= gmem[in_idx];
      b_rd    <= bmem[in_idx];
      s2_beta <= b_rd;
      for (int k = 0; k < LANES; k++)
        prod[k] <= $signed(s1_q[k*IN_W +: IN_W]) * $signed(g_rd[k*G_W +: G_W]);
    end
  end

  // The wide intermediate holds the exact sum, so saturation and wrap are both exact.
  function automatic logic [OUT_W-1:0] affine(input logic signed [P_W-1:0] p,
                                              input logic signed [B_W-1:0] b,
                                              input logic sat);
    logic signed [BIG_W-1:0] sum;
    sum = (BIG_W'(p) >>> SHIFT) + BIG_W'(b);
    if (sat && (sum > SAT_MAX)) return {1'b0, {(OUT_W-1){1'b1}}};
    if (sat && (sum < SAT_MIN)) return {1'b1, {(OUT_W-1){1'b0}}};
    return sum[OUT_W-1:0];
  endfunction

  logic [LANES*OUT_W-1:0] res;
  always_comb begin
    res = '0;
    for (int k = 0; k < LANES; k++)
      res[k*OUT_W +: OUT_W] = affine(prod[k], $signed(s2_beta[k*B_W +: B_W]), sat_r);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid    <= 1'b0;
      s2_valid    <= 1'b0;
      qout_tvalid <= 1'b0;
      qout_tdata  <= '0;
    end else if (en) begin
      s1_valid    <= q_acc;
      s2_valid    <= s1_valid;
      qout_tvalid <= s2_valid;
      qout_tdata  <= res;
    end
  end

endmodule

// File: tb/tb_ln_affine_stream.sv
// Directed bench for ln_affine_stream: vector table plus load/run/stall/reset sequences
// on a single-lane instance and a four-lane instance.
module tb_ln_affine_stream;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // single-lane instance
  logic        rst, p_tvalid, p_tlast, p_tready, qin_tvalid, qin_tready;
  logic        qout_tvalid, qout_tlast, qout_tready, sat_en, err_len, loaded;
  logic [31:0] p_tdata, qout_tdata;
  logic [21:0] qin_tdata;
  logic [23:0] dim1, dim2;

  ln_affine_stream u_dut (
    .clk(clk), .rst(rst),
    .p_tdata(p_tdata), .p_tvalid(p_tvalid), .p_tlast(p_tlast), .p_tready(p_tready),
    .qin_tdata(qin_tdata), .qin_tvalid(qin_tvalid), .qin_tready(qin_tready),
    .qout_tdata(qout_tdata), .qout_tvalid(qout_tvalid), .qout_tlast(qout_tlast),
    .qout_tready(qout_tready), .DIM1(dim1), .DIM2(dim2), .sat_en(sat_en),
    .err_len(err_len), .loaded(loaded)
  );

  // four-lane instance
  logic         rst4, p4_tvalid, p4_tlast, p4_tready, qin4_tvalid, qin4_tready;
  logic         qout4_tvalid, qout4_tlast, qout4_tready, sat4, err4, loaded4;
  logic [31:0]  p4_tdata;
  logic [87:0]  qin4_tdata;
  logic [127:0] qout4_tdata;
  logic [23:0]  dim1_4, dim2_4;

  ln_affine_stream #(.LANES(4)) u_dut4 (
    .clk(clk), .rst(rst4),
    .p_tdata(p4_tdata), .p_tvalid(p4_tvalid), .p_tlast(p4_tlast), .p_tready(p4_tready),
    .qin_tdata(qin4_tdata), .qin_tvalid(qin4_tvalid), .qin_tready(qin4_tready),
    .qout_tdata(qout4_tdata), .qout_tvalid(qout4_tvalid), .qout_tlast(qout4_tlast),
    .qout_tready(qout4_tready), .DIM1(dim1_4), .DIM2(dim2_4), .sat_en(sat4),
    .err_len(err4), .loaded(loaded4)
  );

  int          g_tab [768];
  int          b_tab [768];
  int          q_tab [3072];
  logic [31:0] out_log [3072];
  int          last_lat;

  typedef struct {
    int          g;
    int          b;
    int          q;
    bit          sat;
    logic [31:0] exp;
  } vec_t;
  vec_t vecs [11];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Golden model in 64-bit integer arithmetic.
  function automatic logic [31:0] model(input int q, input int g, input int b, input bit sat);
    longint p, s;
    p = longint'(q) * longint'(g);
    s = (p >>> 8) + longint'(b);
    if (sat && s > 64'sd2147483647)  s = 64'sd2147483647;
    if (sat && s < -64'sd2147483648) s = -64'sd2147483648;
    return s[31:0];
  endfunction

  task automatic reset1(input int d1, input int d2, input bit sat);
    @(negedge clk);
    rst = 1'b1; dim1 = 24'(d1); dim2 = 24'(d2); sat_en = sat;
    p_tvalid = 1'b0; p_tlast = 1'b0; qin_tvalid = 1'b0; qout_tready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic load1(input int n, input int tlast_pos);
    for (int i = 0; i < 2*n; i++) begin
      int guard;
      @(negedge clk);
      p_tvalid = 1'b1;
      p_tdata  = (i < n) ? g_tab[i] : b_tab[i-n];
      p_tlast  = (i == tlast_pos);
      #1;
      guard = 0;
      while (!p_tready && guard < 50) begin
        @(negedge clk); #1; guard++;
      end
      if (guard >= 50) begin
        check("p_tready_timeout", p_tready, 1);
        break;
      end
      @(posedge clk);
    end
    @(negedge clk);
    p_tvalid = 1'b0; p_tlast = 1'b0;
  endtask

  // Streams d1*d2 beats from q_tab, checks every accepted output and stall stability.
  task automatic run_matrix(input int d1, input int d2, input int stall, input bit sat, input string tag);
    int total, in_i, out_i, cyc, acc_cyc, val_cyc;
    logic        held_v;
    logic [31:0] held_d;
    total = d1 * d2; in_i = 0; out_i = 0; cyc = 0; acc_cyc = -1; val_cyc = -1; held_v = 1'b0;
    held_d = '0;
    while (out_i < total && cyc < 40000) begin
      @(negedge clk);
      qout_tready = ($urandom_range(0, 99) >= stall);
      qin_tvalid  = (in_i < total);
      qin_tdata   = (in_i < total) ? 22'(q_tab[in_i]) : '0;
      #1;
      if (held_v) begin
        check({tag, "_hold"}, {qout_tvalid, qout_tdata}, {1'b1, held_d});
        held_v = 1'b0;
      end
      if (qin_tvalid && qin_tready) begin
        if (acc_cyc < 0) acc_cyc = cyc;
        in_i++;
      end
      if (qout_tvalid) begin
        if (val_cyc < 0) val_cyc = cyc;
        if (qout_tready) begin
          check($sformatf("%s_data%0d", tag, out_i), qout_tdata,
                model(q_tab[out_i], g_tab[out_i % d2], b_tab[out_i % d2], sat));
          check($sformatf("%s_last%0d", tag, out_i), qout_tlast, (out_i == total - 1));
          out_log[out_i] = qout_tdata;
          out_i++;
        end else begin
          held_v = 1'b1;
          held_d = qout_tdata;
        end
      end
      cyc++;
    end
    @(negedge clk);
    qin_tvalid = 1'b0; qout_tready = 1'b1;
    check({tag, "_beats"}, out_i, total);
    last_lat = val_cyc - acc_cyc;
  endtask

  initial begin
    int ga [4];
    int ba [4];
    logic [31:0] hand [4];
    logic seen;

    vecs[0]  = '{256,   10,                5,        1'b1, 32'd15};
    vecs[1]  = '{-256,  5,                 5,        1'b1, 32'd0};
    vecs[2]  = '{128,   -3,                5,        1'b1, 32'hFFFF_FFFF};
    vecs[3]  = '{1,     0,                 -1,       1'b1, 32'hFFFF_FFFF};
    vecs[4]  = '{1,     0,                 -255,     1'b1, 32'hFFFF_FFFF};
    vecs[5]  = '{1,     0,                 -257,     1'b1, 32'hFFFF_FFFE};
    vecs[6]  = '{32767, 2147483647,        2097151,  1'b1, 32'h7FFF_FFFF};
    vecs[7]  = '{32767, 2147483647,        2097151,  1'b0, 32'h8FFF_DF7F};
    vecs[8]  = '{32767, int'(32'h8000_0000), -2097152, 1'b1, 32'h8000_0000};
    vecs[9]  = '{32767, int'(32'h8000_0000), -2097152, 1'b0, 32'h7000_2000};
    vecs[10] = '{-32768, 0,                -2097152, 1'b1, 32'h1000_0000};

    // reset state, both instances
    rst = 1'b1; rst4 = 1'b1; dim1 = 24'd2; dim2 = 24'd4; sat_en = 1'b1;
    p_tvalid = 1'b0; p_tlast = 1'b0; p_tdata = '0; qin_tvalid = 1'b0; qin_tdata = '0; qout_tready = 1'b1;
    dim1_4 = 24'd2; dim2_4 = 24'd8; sat4 = 1'b1;
    p4_tvalid = 1'b0; p4_tlast = 1'b0; p4_tdata = '0; qin4_tvalid = 1'b0; qin4_tdata = '0; qout4_tready = 1'b1;
    @(negedge clk); @(negedge clk);
    check("rst_p_tready",   p_tready, 0);
    check("rst_qin_tready", qin_tready, 0);
    check("rst_qout_valid", qout_tvalid, 0);
    check("rst_qout_last",  qout_tlast, 0);
    check("rst_qout_data",  qout_tdata, 0);
    check("rst_err_len",    err_len, 0);
    check("rst_loaded",     loaded, 0);
    rst = 1'b0; rst4 = 1'b0;
    #1;
    check("load_g_p_tready", p_tready, 1);

    // basic matrix; live DIM changes during load must be ignored
    ga = '{256, 512, -256, 128};
    ba = '{10, 0, 5, -3};
    for (int i = 0; i < 4; i++) begin g_tab[i] = ga[i]; b_tab[i] = ba[i]; end
    for (int i = 0; i < 8; i++) q_tab[i] = 5;
    reset1(2, 4, 1'b1);
    dim1 = 24'd5; dim2 = 24'd3;
    load1(4, 7);
    #1;
    check("first_qin_ready", qin_tready, 1);
    check("run_p_tready",    p_tready, 0);
    check("run_loaded",      loaded, 1);
    check("good_err_len",    err_len, 0);
    dim1 = 24'd2; dim2 = 24'd4;
    run_matrix(2, 4, 0, 1'b1, "basic");
    check("latency", last_lat, 3);
    hand = '{32'd15, 32'd10, 32'd0, 32'hFFFF_FFFF};
    for (int i = 0; i < 8; i++) check($sformatf("basic_hand%0d", i), out_log[i], hand[i % 4]);

    // single-element vector table: floor, saturation, wrap
    for (int i = 0; i < 11; i++) begin
      reset1(1, 1, vecs[i].sat);
      g_tab[0] = vecs[i].g; b_tab[0] = vecs[i].b; q_tab[0] = vecs[i].q;
      load1(1, 1);
      run_matrix(1, 1, 0, vecs[i].sat, $sformatf("vec%0d", i));
      check($sformatf("vec%0d_hand", i), out_log[0], vecs[i].exp);
    end

    // early p_tlast: sticky error, load still counts words
    for (int i = 0; i < 4; i++) begin g_tab[i] = ga[i]; b_tab[i] = ba[i]; end
    q_tab[0] = 100; q_tab[1] = -100; q_tab[2] = 7; q_tab[3] = 1048576;
    reset1(1, 4, 1'b1);
    check("err_clear_by_rst", err_len, 0);
    load1(4, 3);
    check("err_set", err_len, 1);
    run_matrix(1, 4, 0, 1'b1, "errrun");
    check("err_sticky_run", err_len, 1);
    load1(4, 7);
    check("err_sticky_reload", err_len, 1);
    run_matrix(1, 4, 20, 1'b1, "errrun2");

    // full-size matrix with 50% backpressure
    for (int i = 0; i < 768; i++) begin
      g_tab[i] = int'($urandom_range(0, 65535)) - 32768;
      b_tab[i] = int'($urandom);
    end
    for (int i = 0; i < 3072; i++) q_tab[i] = int'($urandom_range(0, 4194303)) - 2097152;
    reset1(4, 768, 1'b1);
    load1(768, 1535);
    run_matrix(4, 768, 50, 1'b1, "big");

    // reset two cycles into RUN, then reload with new vectors, twice
    for (int i = 0; i < 4; i++) begin g_tab[i] = ga[i]; b_tab[i] = ba[i]; end
    reset1(2, 4, 1'b1);
    load1(4, 7);
    qin_tvalid = 1'b1; qin_tdata = 22'd5; qout_tready = 1'b1;
    @(negedge clk); @(negedge clk);
    rst = 1'b1; qin_tvalid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 6; c++) begin
      #1; if (qout_tvalid) seen = 1'b1;
      @(negedge clk);
    end
    check("no_stale_beats", seen, 0);
    check("rst_back_to_load", p_tready, 1);
    ga = '{-512, 256, 1024, 0};
    ba = '{1, 2, 3, 4};
    for (int i = 0; i < 4; i++) begin g_tab[i] = ga[i]; b_tab[i] = ba[i]; end
    for (int i = 0; i < 8; i++) q_tab[i] = 5;
    load1(4, 7);
    run_matrix(2, 4, 30, 1'b1, "reload1");
    hand = '{32'hFFFF_FFF7, 32'd7, 32'd23, 32'd4};
    for (int i = 0; i < 8; i++) check($sformatf("reload1_hand%0d", i), out_log[i], hand[i % 4]);
    for (int i = 0; i < 4; i++) begin g_tab[i] = 256 * (i + 2); b_tab[i] = -7 * i; end
    for (int i = 0; i < 8; i++) q_tab[i] = 3 * i - 10;
    load1(4, 7);
    run_matrix(2, 4, 0, 1'b1, "reload2");

    // four lanes, DIM1=2, DIM2=8: gamma[c]=256*(c+1), beta[c]=100*c, q=row*10+c+1
    for (int i = 0; i < 16; i++) begin
      int guard;
      @(negedge clk);
      p4_tvalid = 1'b1;
      p4_tdata  = (i < 8) ? 256 * (i + 1) : 100 * (i - 8);
      p4_tlast  = (i == 15);
      #1;
      guard = 0;
      while (!p4_tready && guard < 50) begin
        @(negedge clk); #1; guard++;
      end
      if (guard >= 50) begin
        check("l4_p_tready_timeout", p4_tready, 1);
        break;
      end
      @(posedge clk);
    end
    @(negedge clk);
    p4_tvalid = 1'b0; p4_tlast = 1'b0;
    check("l4_err_len", err4, 0);
    check("l4_loaded",  loaded4, 1);
    begin
      int in_b, out_b, cyc;
      in_b = 0; out_b = 0; cyc = 0;
      while (out_b < 4 && cyc < 60) begin
        @(negedge clk);
        qin4_tvalid = (in_b < 4);
        for (int l = 0; l < 4; l++)
          qin4_tdata[l*22 +: 22] = 22'((in_b / 2) * 10 + (in_b % 2) * 4 + l + 1);
        #1;
        if (qin4_tvalid && qin4_tready) in_b++;
        if (qout4_tvalid) begin
          for (int l = 0; l < 4; l++) begin
            int col, q;
            col = (out_b % 2) * 4 + l;
            q   = (out_b / 2) * 10 + col + 1;
            check($sformatf("l4_beat%0d_lane%0d", out_b, l), qout4_tdata[l*32 +: 32],
                  32'(q * (col + 1) + 100 * col));
          end
          check($sformatf("l4_last%0d", out_b), qout4_tlast, (out_b == 3));
          out_b++;
        end
        cyc++;
      end
      @(negedge clk);
      qin4_tvalid = 1'b0;
      check("l4_beats", out_b, 4);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
